pipe_queue_stage: RTL

PIPE_QUEUE_STAGE -- requirements
Module: pipe_queue_stage

---
 rtl/pipe_queue_stage.sv | 86 ++++++++
 1 files changed

// File: rtl/pipe_queue_stage.sv
// Circular-buffer FIFO stage with valid/allowin handshakes on both sides and a flush.
// Define PIPE_QUEUE_BYPASS_EN to let an empty queue forward in_bus combinationally.
module pipe_queue_stage #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_bus,
    output logic                     in_allowin,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_bus,
    input  logic                     out_allowin,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    generate
        if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
            $error("pipe_queue_stage: WIDTH must be >=1 and DEPTH a power of two >=2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             pass;
    logic             store;
    logic             advance_head;

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign in_allowin = ~full | out_allowin | flush;

`ifdef PIPE_QUEUE_BYPASS_EN
    assign out_valid = (~empty | in_valid) & ~flush;
    assign out_bus   = empty ? in_bus : mem[head];
    // Empty queue with both sides ready: the payload flows straight through, no state change.
    assign pass      = empty & push & pop;
`else
    assign out_valid = ~empty & ~flush;
    assign out_bus   = mem[head];
    assign pass      = 1'b0;
`endif

    assign push         = in_valid & in_allowin & ~flush;
    assign pop          = out_valid & out_allowin;
    assign store        = push & ~pass;
    assign advance_head = pop & ~pass;

    always_ff @(posedge clk) begin
        if (store) begin
            mem[tail] <= in_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (store) begin
                tail <= tail + PW'(1);
            end
            if (advance_head) begin
                head <= head + PW'(1);
            end
            case ({store, advance_head})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
